// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if: request/response bundle for a group of p_n memory ports
// that share one response data bus. The arbiter uses it twice: once on the
// client side (p_n clients) and once on the memory side (p_n = 1, with the
// opaque field widened to carry the client id).
interface mem_arbiter_rr_if #(
  parameter int p_n         = 1,
  parameter int p_opaq_bits = 8,
  parameter int p_addr_bits = 32,
  parameter int p_data_bits = 32
);
  logic [p_n-1:0]             req_val;
  logic [p_n-1:0]             req_rdy;
  logic [p_n-1:0]             req_op;
  logic [p_n*p_addr_bits-1:0] req_addr;
  logic [p_n*p_data_bits-1:0] req_wdata;
  logic [p_n*p_opaq_bits-1:0] req_opaq;

  logic [p_n-1:0]             resp_val;
  logic [p_n-1:0]             resp_rdy;
  logic                       resp_op;
  logic [p_data_bits-1:0]     resp_rdata;
  logic [p_opaq_bits-1:0]     resp_opaq;

  // The requester side: issues requests, consumes responses.
  modport master (
    output req_val, req_op, req_addr, req_wdata, req_opaq, resp_rdy,
    input  req_rdy, resp_val, resp_op, resp_rdata, resp_opaq
  );

  // The memory side: accepts requests, produces responses.
  modport slave (
    input  req_val, req_op, req_addr, req_wdata, req_opaq, resp_rdy,
    output req_rdy, resp_val, resp_op, resp_rdata, resp_opaq
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: round-robin arbiter letting p_num_clients requesters share a
// single in-order memory port. Requests pass through combinationally with the
// client id prepended to the opaque field; responses are steered back by that
// tag. Each client is limited to p_max_inflight outstanding requests.
// Optional feature: define MEM_ARB_STATS_EN to get per-client grant counters
// on stat_grants; otherwise stat_grants is tied to zero.
module mem_arbiter_rr #(
  parameter int p_num_clients  = 2,
  parameter int p_opaq_bits    = 8,
  parameter int p_addr_bits    = 32,
  parameter int p_data_bits    = 32,
  parameter int p_max_inflight = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  mem_arbiter_rr_if.slave            cli,
  mem_arbiter_rr_if.master           mem,
  output logic [p_num_clients*32-1:0] stat_grants
);

  localparam int N  = p_num_clients;
  localparam int O  = p_opaq_bits;
  localparam int A  = p_addr_bits;
  localparam int D  = p_data_bits;
  localparam int M  = p_max_inflight;
  localparam int ID = $clog2(N);
  localparam int IW = $clog2(M + 1);

  logic [ID-1:0] rrPtr_q, rrPtr_d;
  logic [IW-1:0] inflight_q [N];
  logic [IW-1:0] inflight_d [N];

  logic [N-1:0]  eligible;
  logic          anyEligible;
  logic [ID-1:0] grant;
  logic          reqFire;
  logic [N-1:0]  grantVec;

  logic [ID-1:0] tag;
  logic          tagValid;
  logic [N-1:0]  respFire;

  // A client may compete only while it has request credit left.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      eligible[i] = cli.req_val[i] && (inflight_q[i] < IW'(M));
    end
  end

  // Pick the first eligible client at or after the round-robin pointer.
  always_comb begin
    int idx;
    idx         = 0;
    grant       = rrPtr_q;
    anyEligible = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rrPtr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!anyEligible && eligible[idx]) begin
        anyEligible = 1'b1;
        grant       = ID'(idx);
      end
    end
  end

  // Forward the granted client's request and hand ready back only to it.
  always_comb begin
    mem.req_val   = anyEligible;
    mem.req_op    = cli.req_op[grant];
    mem.req_addr  = cli.req_addr[int'(grant)*A +: A];
    mem.req_wdata = cli.req_wdata[int'(grant)*D +: D];
    mem.req_opaq  = {grant, cli.req_opaq[int'(grant)*O +: O]};
    reqFire       = anyEligible && mem.req_rdy[0];
    cli.req_rdy   = '0;
    grantVec      = '0;
    for (int i = 0; i < N; i++) begin
      grantVec[i]    = reqFire && (grant == ID'(i));
      cli.req_rdy[i] = grantVec[i];
    end
  end

  // Advance past the winner only when its request actually transfers.
  always_comb begin
    rrPtr_d = rrPtr_q;
    if (reqFire) begin
      rrPtr_d = (grant == ID'(N - 1)) ? '0 : grant + 1'b1;
    end
  end

  assign tag = mem.resp_opaq[O+ID-1:O];

  if ((1 << ID) == N) begin : gTagFull
    assign tagValid = 1'b1;
  end else begin : gTagCheck
    assign tagValid = (int'(tag) < N);
  end

  // Steer the memory response to the tagged client; bad tags are swallowed.
  always_comb begin
    cli.resp_val   = '0;
    respFire       = '0;
    mem.resp_rdy   = 1'b1;
    cli.resp_op    = mem.resp_op;
    cli.resp_rdata = mem.resp_rdata;
    cli.resp_opaq  = mem.resp_opaq[O-1:0];
    if (tagValid) begin
      cli.resp_val[tag] = mem.resp_val[0];
      mem.resp_rdy      = cli.resp_rdy[tag];
      respFire[tag]     = mem.resp_val[0] && cli.resp_rdy[tag];
    end
  end

  // Credit bookkeeping: issue adds one, response returns one, both cancel.
  // Decrement saturates so responses to pre-reset requests are harmless.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      inflight_d[i] = inflight_q[i];
      if (grantVec[i] && !respFire[i]) begin
        inflight_d[i] = inflight_q[i] + IW'(1);
      end else if (respFire[i] && !grantVec[i] && (inflight_q[i] != '0)) begin
        inflight_d[i] = inflight_q[i] - IW'(1);
      end
    end
  end

  // Arbitration pointer and credit counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr_q <= '0;
      for (int i = 0; i < N; i++) inflight_q[i] <= '0;
    end else begin
      rrPtr_q <= rrPtr_d;
      for (int i = 0; i < N; i++) inflight_q[i] <= inflight_d[i];
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] statCnt_q [N];

  // Count every transferred request per client, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) statCnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (grantVec[i]) statCnt_q[i] <= statCnt_q[i] + 32'd1;
      end
    end
  end

  // Flatten the counters onto the status bus.
  always_comb begin
    for (int i = 0; i < N; i++) stat_grants[i*32 +: 32] = statCnt_q[i];
  end
`else
  assign stat_grants = '0;
`endif

`ifndef SYNTHESIS
  // A tag beyond the client range means the memory returned garbage.
  always_ff @(posedge clk) begin
    if (!rst && mem.resp_val[0]) begin
      assert (tagValid)
        else $error("mem_arbiter_rr: response tag %0d out of range", tag);
    end
  end

  function automatic string trace();
    string s;
    s = "  ";
    if (reqFire) s = $sformatf("g%0d", grant);
    if (mem.resp_val[0] && mem.resp_rdy[0]) begin
      s = reqFire ? {s, $sformatf("r%0d", tag)} : $sformatf("r%0d", tag);
    end
    return s;
  endfunction
`endif

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: scoreboard bench for mem_arbiter_rr with two clients and
// two credits per client. A small memory model answers requests in order; the
// expected client-side response is queued when each request is driven.
`timescale 1ns/1ps
module tb_mem_arbiter_rr;

  localparam int N  = 2;
  localparam int O  = 8;
  localparam int A  = 32;
  localparam int D  = 32;
  localparam int M  = 2;
  localparam int ID = 1;
  localparam logic [D-1:0] RdKey = 32'h5A5A_0000;

  logic clk = 1'b0;
  logic rst;
  logic [N*32-1:0] stat_grants;

  always #5 clk = ~clk;

  mem_arbiter_rr_if #(.p_n(N), .p_opaq_bits(O), .p_addr_bits(A), .p_data_bits(D)) cliBus();
  mem_arbiter_rr_if #(.p_n(1), .p_opaq_bits(O + ID), .p_addr_bits(A), .p_data_bits(D)) memBus();

  mem_arbiter_rr #(
    .p_num_clients(N), .p_opaq_bits(O), .p_addr_bits(A),
    .p_data_bits(D), .p_max_inflight(M)
  ) dut (
    .clk(clk), .rst(rst), .cli(cliBus), .mem(memBus), .stat_grants(stat_grants)
  );

  typedef struct packed {
    logic          op;
    logic [A-1:0]  addr;
    logic [D-1:0]  wdata;
    logic [O+ID-1:0] opaq;
  } memReq_t;

  typedef struct packed {
    int           client;
    logic         op;
    logic [D-1:0] rdata;
    logic [O-1:0] opaq;
  } expResp_t;

  memReq_t  memQ[$];
  expResp_t respQ[$];
  int checks = 0;
  int failures = 0;
  int seq = 0;
  int grantCount[N];
  logic         cOp[N];
  logic [A-1:0] cAddr[N];
  logic [D-1:0] cWdata[N];
  logic [O-1:0] cOpaq[N];

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    cliBus.req_val = '0; cliBus.req_op = '0; cliBus.req_addr = '0;
    cliBus.req_wdata = '0; cliBus.req_opaq = '0; cliBus.resp_rdy = '0;
    memBus.req_rdy = '0; memBus.resp_val = '0; memBus.resp_op = 1'b0;
    memBus.resp_rdata = '0; memBus.resp_opaq = '0;
  endtask

  // Fresh payload for every client each cycle, plus valids and memory ready.
  task automatic applyStimulus(input logic [N-1:0] val, input logic memRdy);
    seq++;
    for (int i = 0; i < N; i++) begin
      cOp[i]    = 1'((seq + i) % 2);
      cAddr[i]  = A'(32'h1000_0000 * (i + 1) + seq * 16);
      cWdata[i] = cAddr[i] + 32'h0000_0777;
      cOpaq[i]  = O'(seq * 2 + i);
      cliBus.req_op[i]             = cOp[i];
      cliBus.req_addr[i*A +: A]    = cAddr[i];
      cliBus.req_wdata[i*D +: D]   = cWdata[i];
      cliBus.req_opaq[i*O +: O]    = cOpaq[i];
    end
    cliBus.req_val = val;
    memBus.req_rdy = memRdy;
  endtask

  // Memory model captures a transferred request; scoreboard gets the reply
  // that client c should eventually see, built from what the bench drove.
  task automatic recordFire(input int c);
    if (memBus.req_val[0] && memBus.req_rdy[0]) begin
      memQ.push_back('{op: memBus.req_op[0], addr: memBus.req_addr,
                       wdata: memBus.req_wdata, opaq: memBus.req_opaq});
      respQ.push_back('{client: c, op: cOp[c],
                        rdata: cAddr[c] ^ cWdata[c] ^ RdKey, opaq: cOpaq[c]});
      grantCount[c]++;
    end
  endtask

  task automatic driveResp(input memReq_t m);
    memBus.resp_val   = 1'b1;
    memBus.resp_op    = m.op;
    memBus.resp_rdata = m.addr ^ m.wdata ^ RdKey;
    memBus.resp_opaq  = m.opaq;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idleInputs();
    repeat (2) nextCycle();
    @(negedge clk);
    checks++; if (memBus.req_val !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_req_val: got %b expected 0", memBus.req_val); end
    checks++; if (cliBus.req_rdy !== 2'b00) begin failures++; $display("[TB] FAIL reset_cli_req_rdy: got %b expected 00", cliBus.req_rdy); end
    checks++; if (cliBus.resp_val !== 2'b00) begin failures++; $display("[TB] FAIL reset_cli_resp_val: got %b expected 00", cliBus.resp_val); end
    checks++; if (memBus.resp_rdy !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_resp_rdy: got %b expected 0", memBus.resp_rdy); end
    checks++; if (stat_grants !== '0) begin failures++; $display("[TB] FAIL reset_stats: got %h expected 0", stat_grants); end
    nextCycle();
    rst = 1'b0;
  endtask

  // Drain every outstanding request and compare each routed response.
  task automatic test_responses();
    memReq_t m;
    expResp_t e;
    cliBus.req_val = '0;
    memBus.req_rdy = 1'b0;
    for (int k = 0; k < 16 && memQ.size() > 0; k++) begin
      m = memQ.pop_front();
      e = respQ.pop_front();
      driveResp(m);
      cliBus.resp_rdy = '1;
      @(negedge clk);
      checks++;
      if (cliBus.resp_val !== N'(1 << e.client) || memBus.resp_rdy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL resp_route: got val=%b mem_rdy=%b expected val=%b mem_rdy=1", cliBus.resp_val, memBus.resp_rdy, N'(1 << e.client));
      end
      checks++;
      if (cliBus.resp_rdata !== e.rdata || cliBus.resp_opaq !== e.opaq || cliBus.resp_op !== e.op) begin
        failures++;
        $display("[TB] FAIL resp_payload: got data=%h opaq=%h op=%b expected data=%h opaq=%h op=%b", cliBus.resp_rdata, cliBus.resp_opaq, cliBus.resp_op, e.rdata, e.opaq, e.op);
      end
      nextCycle();
    end
    memBus.resp_val = 1'b0;
    cliBus.resp_rdy = '0;
  endtask

  task automatic test_alternate();
    int pattern[4] = '{0, 1, 0, 1};
    int expGrant[$];
    int g;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b11, 1'b1);
      expGrant.push_back(pattern[k]);
      @(negedge clk);
      g = expGrant.pop_front();
      checks++; if (memBus.req_opaq[O+ID-1:O] !== ID'(g)) begin failures++; $display("[TB] FAIL alt_tag_%0d: got %0d expected %0d", k, memBus.req_opaq[O+ID-1:O], g); end
      checks++; if (cliBus.req_rdy !== N'(1 << g)) begin failures++; $display("[TB] FAIL alt_rdy_%0d: got %b expected %b", k, cliBus.req_rdy, N'(1 << g)); end
      recordFire(g);
      nextCycle();
    end
    applyStimulus(2'b11, 1'b1);
    @(negedge clk);
    checks++; if (memBus.req_val !== 1'b0) begin failures++; $display("[TB] FAIL alt_credit_block: got %b expected 0", memBus.req_val); end
    nextCycle();
    test_responses();
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b10, 1'b0);
      @(negedge clk);
      checks++; if (cliBus.req_rdy !== 2'b00) begin failures++; $display("[TB] FAIL stall_rdy_%0d: got %b expected 00", k, cliBus.req_rdy); end
      checks++; if (memBus.req_val !== 1'b1 || memBus.req_opaq[O+ID-1:O] !== 1'b1) begin failures++; $display("[TB] FAIL stall_grant_%0d: got val=%b tag=%b expected val=1 tag=1", k, memBus.req_val, memBus.req_opaq[O+ID-1:O]); end
      nextCycle();
    end
    applyStimulus(2'b10, 1'b1);
    @(negedge clk);
    checks++; if (cliBus.req_rdy !== 2'b10) begin failures++; $display("[TB] FAIL stall_fire: got %b expected 10", cliBus.req_rdy); end
    recordFire(1);
    nextCycle();
    applyStimulus(2'b11, 1'b1);
    @(negedge clk);
    checks++; if (cliBus.req_rdy !== 2'b01) begin failures++; $display("[TB] FAIL stall_ptr_wrap: got %b expected 01", cliBus.req_rdy); end
    recordFire(0);
    nextCycle();
    test_responses();
  endtask

  task automatic test_max_inflight();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(2'b01, 1'b1);
      @(negedge clk);
      checks++; if (cliBus.req_rdy !== 2'b01) begin failures++; $display("[TB] FAIL maxinf_issue_%0d: got %b expected 01", k, cliBus.req_rdy); end
      recordFire(0);
      nextCycle();
    end
    applyStimulus(2'b01, 1'b1);
    @(negedge clk);
    checks++; if (cliBus.req_rdy !== 2'b00 || memBus.req_val !== 1'b0) begin failures++; $display("[TB] FAIL maxinf_third: got rdy=%b val=%b expected rdy=00 val=0", cliBus.req_rdy, memBus.req_val); end
    nextCycle();
    applyStimulus(2'b11, 1'b1);
    @(negedge clk);
    checks++; if (cliBus.req_rdy !== 2'b10) begin failures++; $display("[TB] FAIL maxinf_other: got %b expected 10", cliBus.req_rdy); end
    recordFire(1);
    nextCycle();
    test_responses();
  endtask

  task automatic test_resp_backpressure();
    memReq_t m;
    expResp_t e;
    applyStimulus(2'b10, 1'b1);
    @(negedge clk);
    checks++; if (cliBus.req_rdy !== 2'b10) begin failures++; $display("[TB] FAIL bp_issue: got %b expected 10", cliBus.req_rdy); end
    recordFire(1);
    nextCycle();
    applyStimulus(2'b00, 1'b0);
    if (memQ.size() == 0) begin
      checks++; failures++;
      $display("[TB] FAIL bp_no_request: got 0 queued expected 1");
      return;
    end
    m = memQ.pop_front();
    e = respQ.pop_front();
    driveResp(m);
    cliBus.resp_rdy = 2'b01;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (memBus.resp_rdy !== 1'b0 || cliBus.resp_val !== 2'b10) begin failures++; $display("[TB] FAIL bp_hold_%0d: got mem_rdy=%b val=%b expected mem_rdy=0 val=10", k, memBus.resp_rdy, cliBus.resp_val); end
      nextCycle();
    end
    cliBus.resp_rdy = 2'b11;
    @(negedge clk);
    checks++; if (memBus.resp_rdy !== 1'b1 || cliBus.resp_val !== 2'b10) begin failures++; $display("[TB] FAIL bp_release: got mem_rdy=%b val=%b expected mem_rdy=1 val=10", memBus.resp_rdy, cliBus.resp_val); end
    checks++; if (cliBus.resp_rdata !== e.rdata || cliBus.resp_opaq !== e.opaq) begin failures++; $display("[TB] FAIL bp_payload: got data=%h opaq=%h expected data=%h opaq=%h", cliBus.resp_rdata, cliBus.resp_opaq, e.rdata, e.opaq); end
    nextCycle();
    memBus.resp_val = 1'b0;
    cliBus.resp_rdy = '0;
  endtask

  task automatic test_same_cycle();
    memReq_t m;
    expResp_t e;
    applyStimulus(2'b01, 1'b1);
    @(negedge clk);
    checks++; if (cliBus.req_rdy !== 2'b01) begin failures++; $display("[TB] FAIL same_first: got %b expected 01", cliBus.req_rdy); end
    recordFire(0);
    nextCycle();
    applyStimulus(2'b01, 1'b1);
    m = memQ.pop_front();
    e = respQ.pop_front();
    driveResp(m);
    cliBus.resp_rdy = 2'b01;
    @(negedge clk);
    checks++; if (cliBus.req_rdy !== 2'b01 || memBus.resp_rdy !== 1'b1 || cliBus.resp_val !== 2'b01) begin failures++; $display("[TB] FAIL same_both: got rdy=%b mem_rdy=%b val=%b expected rdy=01 mem_rdy=1 val=01", cliBus.req_rdy, memBus.resp_rdy, cliBus.resp_val); end
    checks++; if (cliBus.resp_rdata !== e.rdata) begin failures++; $display("[TB] FAIL same_data: got %h expected %h", cliBus.resp_rdata, e.rdata); end
    recordFire(0);
    nextCycle();
    memBus.resp_val = 1'b0;
    cliBus.resp_rdy = '0;
    applyStimulus(2'b01, 1'b1);
    @(negedge clk);
    checks++; if (cliBus.req_rdy !== 2'b01) begin failures++; $display("[TB] FAIL same_second: got %b expected 01", cliBus.req_rdy); end
    recordFire(0);
    nextCycle();
    applyStimulus(2'b01, 1'b1);
    @(negedge clk);
    checks++; if (cliBus.req_rdy !== 2'b00) begin failures++; $display("[TB] FAIL same_limit: got %b expected 00", cliBus.req_rdy); end
    nextCycle();
    test_responses();
  endtask

  task automatic test_stats();
    logic [N*32-1:0] expStat;
    rst = 1'b1;
    applyStimulus(2'b00, 1'b0);
    nextCycle();
    rst = 1'b0;
    for (int i = 0; i < N; i++) grantCount[i] = 0;
    for (int k = 0; k < 7; k++) begin
      int c;
      c = (k < 5) ? 0 : 1;
      applyStimulus(N'(1 << c), 1'b1);
      @(negedge clk);
      checks++; if (cliBus.req_rdy !== N'(1 << c)) begin failures++; $display("[TB] FAIL stats_issue_%0d: got %b expected %b", k, cliBus.req_rdy, N'(1 << c)); end
      recordFire(c);
      nextCycle();
      test_responses();
    end
`ifdef MEM_ARB_STATS_EN
    expStat = {32'(grantCount[1]), 32'(grantCount[0])};
`else
    expStat = '0;
`endif
    @(negedge clk);
    checks++; if (stat_grants !== expStat) begin failures++; $display("[TB] FAIL stats_count: got %h expected %h", stat_grants, expStat); end
    nextCycle();
    applyStimulus(2'b01, 1'b1);
    @(negedge clk);
    recordFire(0);
    nextCycle();
    rst = 1'b1;
    applyStimulus(2'b00, 1'b0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (stat_grants !== '0 || memBus.req_val !== 1'b0) begin failures++; $display("[TB] FAIL stats_reset: got stats=%h val=%b expected 0 0", stat_grants, memBus.req_val); end
    nextCycle();
    test_responses();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b01, 1'b1);
      @(negedge clk);
      checks++; if (cliBus.req_rdy !== ((k < 2) ? 2'b01 : 2'b00)) begin failures++; $display("[TB] FAIL post_reset_credit_%0d: got %b expected %b", k, cliBus.req_rdy, (k < 2) ? 2'b01 : 2'b00); end
      if (k < 2) recordFire(0);
      nextCycle();
    end
    test_responses();
  endtask

  // Bound the whole run so a wedged design still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Run every scenario in order, then report.
  initial begin
    rst = 1'b1;
    idleInputs();
    test_reset();
    test_alternate();
    test_stall();
    test_max_inflight();
    test_resp_backpressure();
    test_same_cycle();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
